uart_rx: RTL

Serial receiver stage that consumes the 8x-oversampled `baud_tick` from the baud generator and the asynchronous `rx` line. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit) and presents each byte with a one-cycle `rx_done` strobe. The strobe and byte feed the RX FIFO write side. Malformed frames are reported on `frame_err`.

---
 rtl/uart_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver driven by an OVERSAMPLE-times baud tick.
// Recovers one byte per frame and flags frames whose stop bit is low.
module uart_rx #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r;
  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  logic [TW-1:0] tick_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [7:0]    rx_data_r;
  logic          rx_done_r;
  logic          rx_busy_r;
  logic          frame_err_r;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Frame FSM; everything advances only on baud ticks, strobes last one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rx_prev_r   <= 1'b1;
      tick_cnt_r  <= '0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      rx_data_r   <= 8'h00;
      rx_done_r   <= 1'b0;
      rx_busy_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      if (baud_tick) begin
        rx_prev_r <= rx_sync_r;
        case (state_r)
          IDLE: begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            // Edge, not level: a line stuck low cannot retrigger.
            if (rx_prev_r && !rx_sync_r) begin
              state_r   <= START;
              rx_busy_r <= 1'b1;
            end else begin
              state_r   <= IDLE;
            end
          end
          START: begin
            if (tick_cnt_r == HALF_M1) begin
              tick_cnt_r <= '0;
              if (!rx_sync_r) begin
                state_r   <= DATA;
              end else begin
                state_r   <= IDLE;
                rx_busy_r <= 1'b0;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt_r == FULL_M1) begin
              tick_cnt_r <= '0;
              shift_r    <= {rx_sync_r, shift_r[7:1]};
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= STOP;
              end else begin
                state_r <= DATA;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
          STOP: begin
            if (tick_cnt_r == FULL_M1) begin
              tick_cnt_r <= '0;
              state_r    <= IDLE;
              rx_busy_r  <= 1'b0;
              if (rx_sync_r) begin
                rx_data_r <= shift_r;
                rx_done_r <= 1'b1;
              end else begin
                frame_err_r <= 1'b1;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
          default: begin
            state_r   <= IDLE;
            rx_busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_done   = rx_done_r;
  assign rx_busy   = rx_busy_r;
  assign frame_err = frame_err_r;

endmodule
